// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg: shared states and frame constants for the UART word rx     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 64;
  localparam int DATA_BITS            = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_byte_rx: 8N1 receiver with input synchronizer, byte + strobe    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  logic             sync1_q, rx_s_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // The strobe is combinational so the word logic can register it one clock after the stop sample.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!rx_s_q) begin
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_q == FULL_LAST) begin
          baud_d  = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_d = STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_q == FULL_LAST) begin
          baud_d     = '0;
          byte_valid = rx_s_q;
          state_d    = IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data = shift_q;

endmodule
`default_nettype wire

// File: rtl/uart_word_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_word_receiver: assembles four UART bytes into a 32-bit word     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_word_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RxD,
  output logic [31:0] RxD_word_data,
  output logic        RxD_word_data_ready
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [31:0] word_q, word_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] data_q, data_d;
  logic        ready_q, ready_d;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (RxD),
    .byte_data (byte_data),
    .byte_valid(byte_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      count_q <= count_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  // First byte of a word ends up in [31:24] after the remaining three shift in behind it.
  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    data_d  = data_q;
    ready_d = 1'b0;
    if (byte_valid) begin
      word_d  = {word_q[23:0], byte_data};
      count_d = count_q + 2'd1;
      if (count_q == LAST_BYTE) begin
        count_d = '0;
        data_d  = {word_q[23:0], byte_data};
        ready_d = 1'b1;
      end
    end
  end

  assign RxD_word_data       = data_q;
  assign RxD_word_data_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_word_receiver: directed scoreboard bench for the word rx     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_word_receiver;

  localparam int BIT_NS = 128;

  logic        clk;
  logic        rst_n;
  logic        RxD;
  logic [31:0] RxD_word_data;
  logic        RxD_word_data_ready;

  int          check_cnt = 0;
  int          pass_cnt  = 0;
  int          pulses    = 0;
  int          exp_pulses = 0;
  logic        prev_ready = 1'b0;
  logic [31:0] exp_q[$];

  uart_word_receiver #(
    .CLKS_PER_BIT  (64),
    .BYTES_PER_WORD(4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .RxD                (RxD),
    .RxD_word_data      (RxD_word_data),
    .RxD_word_data_ready(RxD_word_data_ready)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int idle_bits);
    RxD = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      #(BIT_NS);
    end
    RxD = stop_bit;
    #(BIT_NS);
    RxD = 1'b1;
    #(BIT_NS * idle_bits);
  endtask

  task automatic send_word(input logic [31:0] w, input int idle_bits);
    exp_q.push_back(w);
    exp_pulses++;
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1, idle_bits);
  endtask

  task automatic wait_pulses(input string tag);
    for (int i = 0; i < 20000 && pulses < exp_pulses; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    check(tag, 32'(pulses), 32'(exp_pulses));
  endtask

  // Scoreboard: every ready strobe pops the oldest expected word.
  always @(negedge clk) begin
    if (RxD_word_data_ready) begin
      pulses++;
      check("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
      check("ready_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("word_data", RxD_word_data, exp_q.pop_front());
    end
    prev_ready = RxD_word_data_ready;
  end

  initial begin
    RxD   = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_data", RxD_word_data, 32'd0);
    check("reset_ready", {31'd0, RxD_word_data_ready}, 32'd0);
    rst_n = 1'b1;

    // Nominal word with single idle bits between the middle frames
    #136;
    exp_q.push_back(32'hE1C0CDCF);
    exp_pulses++;
    send_byte(8'hE1, 1'b1, 0);
    send_byte(8'hC0, 1'b1, 1);
    send_byte(8'hCD, 1'b1, 1);
    send_byte(8'hCF, 1'b1, 0);
    wait_pulses("nominal_pulses");
    check("nominal_hold", RxD_word_data, 32'hE1C0CDCF);

    // Back-to-back frames
    send_word(32'h11223344, 0);
    send_word(32'hDEADBEEF, 0);
    wait_pulses("b2b_pulses");

    // Glitch on an idle line
    RxD = 1'b0;
    repeat (10) @(posedge clk);
    RxD = 1'b1;
    #(BIT_NS * 12);
    check("glitch_no_pulse", 32'(pulses), 32'(exp_pulses));
    check("glitch_data_hold", RxD_word_data, 32'hDEADBEEF);
    send_word(32'h5A0FF012, 1);
    wait_pulses("glitch_word_pulses");

    // Framing error on the second byte
    exp_q.push_back(32'h10304050);
    exp_pulses++;
    send_byte(8'h10, 1'b1, 1);
    send_byte(8'h20, 1'b0, 2);
    send_byte(8'h30, 1'b1, 1);
    send_byte(8'h40, 1'b1, 1);
    send_byte(8'h50, 1'b1, 1);
    wait_pulses("framing_pulses");

    // Reset in the middle of the third byte
    send_byte(8'h77, 1'b1, 1);
    send_byte(8'h88, 1'b1, 1);
    RxD = 1'b0;
    #(BIT_NS);
    RxD = 1'b1;
    #(BIT_NS * 3);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_data", RxD_word_data, 32'd0);
    check("midreset_ready", {31'd0, RxD_word_data_ready}, 32'd0);
    rst_n = 1'b1;
    RxD   = 1'b1;
    #(BIT_NS * 8);
    send_word(32'hCAFEF00D, 1);
    wait_pulses("post_reset_pulses");

    // Two consecutive words; first value must hold until the second strobe
    send_word(32'h01020304, 1);
    wait_pulses("two_words_first");
    exp_q.push_back(32'hA5A55A5A);
    exp_pulses++;
    send_byte(8'hA5, 1'b1, 1);
    send_byte(8'hA5, 1'b1, 1);
    check("two_words_hold", RxD_word_data, 32'h01020304);
    send_byte(8'h5A, 1'b1, 1);
    check("two_words_hold_late", RxD_word_data, 32'h01020304);
    send_byte(8'h5A, 1'b1, 1);
    wait_pulses("two_words_second");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
`default_nettype wire
